// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ready memory handshakes.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_controller #(
  parameter int OP_W    = 3,
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    main_op,
  input  logic [FUNCT_W-1:0] alu_in,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_we,
  output logic [ALUOP_W-1:0] alu_out,
  output logic [1:0]         alusrc,
  output logic               en_pc,
  output logic               jump,
  output logic               pcsrc,
  output logic               we_reg,
  output logic               en_ram,
  output logic               we_ram,
  output logic               wrtsrc,
  output logic               rdsrc,
  output logic               illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [2:0] OP_R = 3'd0, OP_ADDI = 3'd1, OP_LW = 3'd2, OP_SW = 3'd3;
  localparam logic [2:0] OP_BEQ = 3'd4, OP_BNE = 3'd5, OP_J = 3'd6, OP_HALT = 3'd7;
  state_t            r_state;
  logic [2:0]        r_op;
  logic [2:0]        r_funct;
  logic              r_illegal;
  logic [2:0]        w_op3;
  logic              w_illegal;
  logic              w_r, w_addi, w_lw, w_sw, w_beq, w_bne, w_j;
  logic              w_exec, w_mem, w_wb, w_alu_hold;
  assign w_op3     = main_op[2:0];
  assign w_illegal = ((main_op >> 3) != '0) || (w_op3 == OP_R && alu_in > FUNCT_W'(5));
  assign w_r    = r_op == OP_R;
  assign w_addi = r_op == OP_ADDI;
  assign w_lw   = r_op == OP_LW;
  assign w_sw   = r_op == OP_SW;
  assign w_beq  = r_op == OP_BEQ;
  assign w_bne  = r_op == OP_BNE;
  assign w_j    = r_op == OP_J;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_funct   <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (imem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_op    <= w_op3;
          r_funct <= alu_in[2:0];
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_state <= (w_op3 == OP_HALT) ? S_HALT : S_EXEC;
          end
        end
        S_EXEC:   r_state <= (w_r || w_addi) ? S_WB : (w_lw || w_sw) ? S_MEM : S_FETCH;
        S_MEM:    if (dmem_ready) r_state <= w_sw ? S_FETCH : S_WB;
        S_WB:     r_state <= S_FETCH;
        default:  r_state <= S_HALT;
      endcase
    end
  end
  assign w_exec     = r_state == S_EXEC;
  assign w_mem      = r_state == S_MEM;
  assign w_wb       = r_state == S_WB;
  // ALU controls stay on through MEM so the RAM address and store data remain stable.
  assign w_alu_hold = w_exec || w_mem;
  assign imem_req = r_state == S_FETCH;
  assign ir_we    = (r_state == S_FETCH) && imem_ready;
  assign alu_out  = !w_alu_hold ? '0 : w_r ? ALUOP_W'(r_funct) : (w_beq || w_bne) ? ALUOP_W'(1) : '0;
  assign alusrc   = (w_alu_hold && (w_addi || w_lw || w_sw)) ? 2'd1 : 2'd0;
  assign rdsrc    = w_alu_hold && w_sw;
  assign en_pc    = (w_exec && (w_beq || w_bne || w_j)) || (w_mem && w_sw && dmem_ready) || w_wb;
  assign jump     = w_exec && w_j;
  assign pcsrc    = w_exec && ((w_beq && zero) || (w_bne && !zero));
  assign we_reg   = w_wb;
  assign wrtsrc   = w_wb && w_lw;
  assign en_ram   = w_mem;
  assign we_ram   = w_mem && w_sw;
  assign illegal  = r_illegal;
  assign halted   = r_state == S_HALT;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_HALT && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (en_pc && r_instr_cnt != '1) r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end
  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked every cycle against a per-instruction trace model.
module tb_multicycle_controller;
  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic [2:0] alu_out;
    logic [1:0] alusrc;
    logic       en_pc;
    logic       jump;
    logic       pcsrc;
    logic       we_reg;
    logic       en_ram;
    logic       we_ram;
    logic       wrtsrc;
    logic       rdsrc;
    logic       illegal;
    logic       halted;
    logic [3:0] cyc;
    logic [3:0] ins;
  } out_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] main_op = '0;
  logic [3:0] alu_in = '0;
  logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, ir_we, en_pc, jump, pcsrc, we_reg, en_ram, we_ram, wrtsrc, rdsrc, illegal, halted;
  logic [2:0] alu_out;
  logic [1:0] alusrc;
  logic [3:0] cycle_cnt, instr_cnt;
  out_t       exp_v, dut_v;
  int         n_chk = 0, n_fail = 0, ncyc = 0, mark = 0, gap = 0, m_cyc = 0, m_ins = 0;
  logic       chk_en = 1'b0, m_ill = 1'b0, m_halt = 1'b0;
  string      ph = "idle";

  multicycle_controller #(.OP_W(3), .FUNCT_W(4), .ALUOP_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .main_op(main_op), .alu_in(alu_in), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .alu_out(alu_out), .alusrc(alusrc), .en_pc(en_pc), .jump(jump), .pcsrc(pcsrc),
    .we_reg(we_reg), .en_ram(en_ram), .we_ram(we_ram), .wrtsrc(wrtsrc), .rdsrc(rdsrc),
    .illegal(illegal), .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;
  assign dut_v = {imem_req, ir_we, alu_out, alusrc, en_pc, jump, pcsrc, we_reg, en_ram, we_ram,
                  wrtsrc, rdsrc, illegal, halted, cycle_cnt, instr_cnt};

  always @(negedge clk) begin
    if (!rst_n) begin
      ncyc = 0;
      mark = 0;
    end else if (chk_en) begin
      n_chk++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cyc%0d got=%h exp=%h", ph, ncyc, dut_v, exp_v);
      end
      ncyc++;
      if (en_pc) begin
        gap = ncyc - mark;
        mark = ncyc;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, want);
    end
  endtask

  task automatic step(input logic imr, input logic dmr, input out_t e, input string p);
    imem_ready = imr;
    dmem_ready = dmr;
    e.illegal = m_ill;
    e.halted = m_halt;
`ifdef CTRL_PERF_CNT_EN
    e.cyc = 4'(m_cyc);
    e.ins = 4'(m_ins);
`else
    e.cyc = '0;
    e.ins = '0;
`endif
    exp_v = e;
    ph = p;
    @(posedge clk);
    #1;
    if (!e.halted && m_cyc < 15) m_cyc++;
    if (e.en_pc && m_ins < 15) m_ins++;
  endtask

  task automatic do_reset();
    out_t rv;
    chk_en = 1'b0;
    rst_n = 1'b0;
    {imem_ready, dmem_ready, zero} = '0;
    main_op = '0;
    alu_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rv = '0;
    rv.imem_req = 1'b1;
    chk("rst_vec", int'(dut_v), int'(rv));
    rst_n = 1'b1;
    m_cyc = 0;
    m_ins = 0;
    m_ill = 1'b0;
    m_halt = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    out_t e;
    repeat (n) begin
      e = '0;
      step(1'b1, 1'b1, e, "halt");
    end
  endtask

  task automatic run(input int op, input int fn, input logic z, input int iw, input int dw, input logic abort);
    out_t e;
    main_op = 3'(op);
    alu_in = 4'(fn);
    zero = z;
    repeat (iw) begin
      e = '0;
      e.imem_req = 1'b1;
      step(1'b0, 1'b0, e, "fetch_wait");
    end
    e = '0;
    e.imem_req = 1'b1;
    e.ir_we = 1'b1;
    step(1'b1, 1'b0, e, "fetch");
    e = '0;
    step(1'b0, 1'b0, e, "decode");
    if (op == 0 && fn > 5) begin
      m_ill = 1'b1;
      m_halt = 1'b1;
      return;
    end
    if (op == 7) begin
      m_halt = 1'b1;
      return;
    end
    e = '0;
    e.alu_out = (op == 0) ? 3'(fn) : (op == 4 || op == 5) ? 3'd1 : 3'd0;
    e.alusrc = (op >= 1 && op <= 3) ? 2'd1 : 2'd0;
    e.rdsrc = op == 3;
    e.en_pc = op >= 4;
    e.jump = op == 6;
    e.pcsrc = (op == 4 && z) || (op == 5 && !z);
    step(1'b0, 1'b0, e, "exec");
    if (op == 2 || op == 3) begin
      e = '0;
      e.alusrc = 2'd1;
      e.rdsrc = op == 3;
      e.en_ram = 1'b1;
      e.we_ram = op == 3;
      if (abort) begin
        dmem_ready = 1'b0;
        #2;
        chk("mem_en_ram", int'(en_ram), 1);
        chk("mem_we_ram", int'(we_ram), 1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_en_ram", int'(en_ram), 0);
        chk("abort_we_ram", int'(we_ram), 0);
        chk("abort_imem_req", int'(imem_req), 1);
        return;
      end
      repeat (dw) step(1'b0, 1'b0, e, "mem_wait");
      e.en_pc = op == 3;
      step(1'b0, 1'b1, e, "mem");
    end
    if (op <= 2) begin
      e = '0;
      e.we_reg = 1'b1;
      e.wrtsrc = op == 2;
      e.en_pc = 1'b1;
      step(1'b0, 1'b0, e, "wb");
    end
  endtask

  initial begin
    do_reset();
    run(0, 0, 1'b0, 0, 0, 1'b0); chk("lat_add", gap, 4);
    run(0, 1, 1'b0, 2, 0, 1'b0); chk("lat_sub_fetch_wait", gap, 6);
    run(0, 5, 1'b0, 0, 0, 1'b0); chk("lat_slt", gap, 4);
    run(1, 0, 1'b0, 0, 0, 1'b0); chk("lat_addi", gap, 4);
    run(2, 0, 1'b0, 0, 3, 1'b0); chk("lat_lw_wait3", gap, 8);
    run(2, 0, 1'b0, 0, 0, 1'b0); chk("lat_lw", gap, 5);
    run(3, 0, 1'b0, 0, 1, 1'b0); chk("lat_sw_wait1", gap, 5);
    run(4, 0, 1'b1, 0, 0, 1'b0); chk("lat_beq_taken", gap, 3);
    run(4, 0, 1'b0, 0, 0, 1'b0); chk("lat_beq_not", gap, 3);
    run(5, 0, 1'b1, 0, 0, 1'b0);
    run(5, 0, 1'b0, 0, 0, 1'b0);
    run(6, 0, 1'b0, 0, 0, 1'b0); chk("lat_j", gap, 3);
    for (int i = 2; i <= 4; i++) run(0, i, 1'b0, 0, 0, 1'b0);
    do_reset();
    run(0, 9, 1'b0, 0, 0, 1'b0);
    idle(3);
    chk("ill9_flag", int'(illegal), 1);
    chk("ill9_halt", int'(halted), 1);
    chk("ill9_no_enpc", mark, 0);
    do_reset();
    run(0, 6, 1'b0, 0, 0, 1'b0);
    idle(2);
    chk("ill6_flag", int'(illegal), 1);
    do_reset();
    run(7, 0, 1'b0, 0, 0, 1'b0);
    idle(3);
    chk("halt_flag", int'(halted), 1);
    chk("halt_not_illegal", int'(illegal), 0);
    do_reset();
    run(3, 0, 1'b0, 0, 0, 1'b1);
    do_reset();
    run(0, 0, 1'b0, 0, 0, 1'b0);
    chk("post_abort_add", gap, 4);
    do_reset();
    repeat (20) run(6, 0, 1'b0, 0, 0, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    chk("instr_cnt_sat", int'(instr_cnt), 15);
    chk("cycle_cnt_sat", int'(cycle_cnt), 15);
`else
    chk("instr_cnt_tied", int'(instr_cnt), 0);
    chk("cycle_cnt_tied", int'(cycle_cnt), 0);
`endif
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
